// File: rtl/audio_pkg.sv
// Shared constants, stereo frame type and sample extension helper for the
// audio receive path.
package audio_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  localparam logic LRC_LEFT_LOW  = 1'b0;
  localparam logic LRC_LEFT_HIGH = 1'b1;

  typedef struct packed {
    logic [31:0] left;
    logic [31:0] right;
  } frame_t;

  // Bits at and above wl take the sign bit (or zero); wl = 32 passes through.
  function automatic logic [31:0] extend_sample(input logic [31:0] raw,
                                                input int          wl,
                                                input logic        sign_ext);
    logic [31:0] res;
    res = raw;
    for (int i = 0; i < 32; i++) begin
      if (i >= wl) res[i] = sign_ext & raw[wl-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Show-ahead frame FIFO: head is visible while not empty, a push on a full
// FIFO without a same-edge pop is dropped and flagged for one cycle.
module audio_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   aud_bclk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign full      = (level == (AW+1)'(DEPTH));
  assign not_empty = (level != '0);
  assign do_pop    = pop && not_empty;
  assign do_push   = push && (!full || do_pop);
  assign dropped   = push && full && !do_pop;
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/audio_rx_stereo.sv
// I2S / left-justified serial receiver: deserialises WL-bit samples, pairs
// left/right into stereo frames and queues them in a show-ahead FIFO.
module audio_rx_stereo
  import audio_pkg::*;
#(
  parameter int   WL         = 24,
  parameter int   MODE       = MODE_I2S,
  parameter logic LEFT_LRC   = LRC_LEFT_LOW,
  parameter logic SIGN_EXT   = 1'b1,
  parameter int   FIFO_DEPTH = 4
) (
  input  logic                        aud_bclk,
  input  logic                        rst_n,
  input  logic                        aud_lrc,
  input  logic                        aud_adcdat,
  input  logic                        rd_en,
  output logic                        frame_valid,
  output logic [31:0]                 left_data,
  output logic [31:0]                 right_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_ovf,
  output logic                        slot_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} rx_state_t;

  localparam int CW = $clog2(WL + 1);

  rx_state_t     state;
  logic [CW-1:0] bit_cnt;
  logic [WL-1:0] shreg;
  logic [WL-1:0] left_hold;
  logic          armed;
  logic          lrc_d0;
  logic          is_left;
  logic          left_pend;
  logic          lrc_edge;
  logic          commit;
  logic          push;
  logic          dropped;
  frame_t        push_frame;
  frame_t        head;

  // The first edge after reset only loads lrc_d0, so a high LRC at release
  // is not mistaken for a slot boundary.
  assign lrc_edge = armed && (aud_lrc != lrc_d0);
  assign commit   = (state == ST_SHIFT) && (bit_cnt == CW'(WL));
  assign push     = commit && !is_left && left_pend;

  always_comb begin
    push_frame       = '0;
    push_frame.left  = extend_sample(32'(left_hold), WL, SIGN_EXT);
    push_frame.right = extend_sample(32'(shreg), WL, SIGN_EXT);
  end

  // A commit and a new slot may share an edge; the slot start is written last
  // so it takes over the state while the commit still sees the old sample.
  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      left_hold <= '0;
      armed     <= 1'b0;
      lrc_d0    <= 1'b0;
      is_left   <= 1'b0;
      left_pend <= 1'b0;
      slot_err  <= 1'b0;
    end else begin
      armed    <= 1'b1;
      lrc_d0   <= aud_lrc;
      slot_err <= 1'b0;
      if (commit) begin
        state <= ST_HOLD;
        if (is_left) begin
          left_hold <= shreg;
          left_pend <= 1'b1;
        end else begin
          left_pend <= 1'b0;
        end
      end
      if (lrc_edge) begin
        if (state == ST_SHIFT && bit_cnt != CW'(WL)) begin
          slot_err  <= 1'b1;
          left_pend <= 1'b0;
        end
        is_left <= (aud_lrc == LEFT_LRC);
        state   <= ST_SHIFT;
        if (MODE == MODE_LJ) begin
          shreg   <= {shreg[WL-2:0], aud_adcdat};
          bit_cnt <= CW'(1);
        end else begin
          bit_cnt <= '0;
        end
      end else if (state == ST_SHIFT && bit_cnt != CW'(WL)) begin
        shreg   <= {shreg[WL-2:0], aud_adcdat};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (dropped) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  audio_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .aud_bclk  (aud_bclk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_frame),
    .pop       (rd_en),
    .head      (head),
    .not_empty (frame_valid),
    .level     (fifo_level),
    .dropped   (dropped)
  );

  assign left_data  = head.left;
  assign right_data = head.right;

endmodule

// File: tb/tb_audio_rx_stereo.sv
// Bench for audio_rx_stereo: an I2S/24-bit sign-extending unit and a
// left-justified/16-bit zero-extending unit against a frame-level model.
module tb_audio_rx_stereo;

  localparam int NU    = 2;
  localparam int DEPTH = 4;

  int   wlv   [NU] = '{24, 16};
  int   offv  [NU] = '{1, 0};
  bit   sextv [NU] = '{1'b1, 1'b0};
  logic leftv [NU] = '{1'b0, 1'b1};

  logic aud_bclk = 1'b0;
  logic rst_n    = 1'b0;
  logic        lrc     [NU];
  logic        dat     [NU];
  logic        rd_en   [NU];
  logic        clr_ovf [NU];
  logic        fv      [NU];
  logic        ovf     [NU];
  logic        serr    [NU];
  logic [31:0] ld      [NU];
  logic [31:0] rdat    [NU];
  logic [2:0]  lvl     [NU];

  int tests  = 0;
  int failed = 0;

  logic [63:0] expq     [NU][$];
  bit          pend     [NU];
  logic [31:0] pendVal  [NU];
  bit          started  [NU];
  bit          complete [NU];
  logic        lastLvl  [NU];
  bit          ovfM     [NU];

  always #5 aud_bclk = ~aud_bclk;

  audio_rx_stereo #(
    .WL(24), .MODE(0), .LEFT_LRC(1'b0), .SIGN_EXT(1'b1), .FIFO_DEPTH(DEPTH)
  ) dut_i2s (
    .aud_bclk(aud_bclk), .rst_n(rst_n), .aud_lrc(lrc[0]), .aud_adcdat(dat[0]),
    .rd_en(rd_en[0]), .frame_valid(fv[0]), .left_data(ld[0]), .right_data(rdat[0]),
    .fifo_level(lvl[0]), .overflow(ovf[0]), .clr_ovf(clr_ovf[0]), .slot_err(serr[0])
  );

  audio_rx_stereo #(
    .WL(16), .MODE(1), .LEFT_LRC(1'b1), .SIGN_EXT(1'b0), .FIFO_DEPTH(DEPTH)
  ) dut_lj (
    .aud_bclk(aud_bclk), .rst_n(rst_n), .aud_lrc(lrc[1]), .aud_adcdat(dat[1]),
    .rd_en(rd_en[1]), .frame_valid(fv[1]), .left_data(ld[1]), .right_data(rdat[1]),
    .fifo_level(lvl[1]), .overflow(ovf[1]), .clr_ovf(clr_ovf[1]), .slot_err(serr[1])
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] maskWl(input int u, input logic [31:0] v);
    if (wlv[u] == 32) return v;
    return v & ((32'd1 << wlv[u]) - 32'd1);
  endfunction

  // Two's-complement widening by arithmetic rather than bit replication.
  function automatic logic [31:0] modelExtend(input int u, input logic [31:0] v);
    longint r;
    r = longint'(v);
    if (sextv[u] && wlv[u] < 32 && r >= (longint'(1) << (wlv[u] - 1)))
      r = r + (longint'(1) << 32) - (longint'(1) << wlv[u]);
    return r[31:0];
  endfunction

  task automatic resetModel(input int u);
    expq[u].delete();
    pend[u]     = 1'b0;
    pendVal[u]  = '0;
    started[u]  = 1'b0;
    complete[u] = 1'b0;
    ovfM[u]     = 1'b0;
    lastLvl[u]  = lrc[u];
  endtask

  task automatic pushModel(input int u, input logic [63:0] f, input bit pop);
    if (pop && expq[u].size() > 0) void'(expq[u].pop_front());
    if (expq[u].size() < DEPTH) expq[u].push_back(f);
    else ovfM[u] = 1'b1;
  endtask

  task automatic checkOutput(input int u, input string tag);
    logic [63:0] h;
    @(negedge aud_bclk);
    h = (expq[u].size() > 0) ? expq[u][0] : 64'd0;
    checkValue({tag, " frame_valid"}, 32'(fv[u]), 32'(expq[u].size() > 0));
    checkValue({tag, " fifo_level"}, 32'(lvl[u]), 32'(expq[u].size()));
    checkValue({tag, " left_data"}, ld[u], h[63:32]);
    checkValue({tag, " right_data"}, rdat[u], h[31:0]);
    checkValue({tag, " overflow"}, 32'(ovf[u]), 32'(ovfM[u]));
  endtask

  // One LRC slot of slotLen BCLKs; MSB placed per format, filler bits random.
  task automatic sendSlot(input int u, input logic level, input logic [31:0] val,
                          input int slotLen, input bit popOnPush, input bit chkLat);
    int   wl       = wlv[u];
    int   off      = offv[u];
    int   last     = off + wl - 1;
    bit   edgeHere = (level != lastLvl[u]);
    bit   expErr   = edgeHere && started[u] && !complete[u];
    bit   fullSlot = (off + wl <= slotLen);
    bit   isLeft   = (level == leftv[u]);
    logic [31:0] v = maskWl(u, val);
    for (int b = 0; b < slotLen; b++) begin
      @(negedge aud_bclk);
      if (b == 1) checkValue($sformatf("u%0d slot_err at slot start", u), 32'(serr[u]), 32'(expErr));
      if (b == 2) checkValue($sformatf("u%0d slot_err one cycle", u), 32'(serr[u]), 32'd0);
      if (chkLat && b == last + 1) checkValue("frame_valid before push edge", 32'(fv[u]), 32'd0);
      if (chkLat && b == last + 2) checkValue("frame_valid after push edge", 32'(fv[u]), 32'd1);
      if (popOnPush) rd_en[u] = (b == last + 1);
      lrc[u] = level;
      dat[u] = (b >= off && b <= last) ? v[wl-1-(b-off)] : 1'($urandom_range(0, 1));
    end
    if (edgeHere) begin
      if (started[u] && !complete[u]) pend[u] = 1'b0;
      started[u]  = 1'b1;
      complete[u] = fullSlot;
      if (fullSlot) begin
        if (isLeft) begin
          pend[u]    = 1'b1;
          pendVal[u] = v;
        end else begin
          if (pend[u]) pushModel(u, {modelExtend(u, pendVal[u]), modelExtend(u, v)}, popOnPush);
          pend[u] = 1'b0;
        end
      end
    end
    lastLvl[u] = level;
  endtask

  task automatic applyStimulus(input int u, input logic [31:0] lv, input logic [31:0] rv,
                               input bit popOnPush, input bit chkLat);
    sendSlot(u, leftv[u], lv, 32, 1'b0, 1'b0);
    sendSlot(u, ~leftv[u], rv, 32, popOnPush, chkLat);
  endtask

  task automatic popFrame(input int u, input string tag);
    @(negedge aud_bclk);
    rd_en[u] = 1'b1;
    @(negedge aud_bclk);
    rd_en[u] = 1'b0;
    if (expq[u].size() > 0) void'(expq[u].pop_front());
    checkOutput(u, tag);
  endtask

  task automatic clearOverflow(input int u);
    @(negedge aud_bclk);
    clr_ovf[u] = 1'b1;
    @(negedge aud_bclk);
    clr_ovf[u] = 1'b0;
    ovfM[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      lrc[u] = 1'b0; dat[u] = 1'b0; rd_en[u] = 1'b0; clr_ovf[u] = 1'b0;
      resetModel(u);
    end
    repeat (3) @(negedge aud_bclk);
    checkOutput(0, "reset u0");
    checkOutput(1, "reset u1");
    checkValue("reset slot_err", 32'(serr[0]), 32'd0);
    rst_n = 1'b1;

    // I2S 24-bit sign-extended frame, with push latency
    sendSlot(0, 1'b1, $urandom, 32, 1'b0, 1'b0);
    applyStimulus(0, 32'h123456, 32'hABCDEF, 1'b0, 1'b1);
    checkOutput(0, "i2s frame");
    checkValue("i2s left const", ld[0], 32'h00123456);
    checkValue("i2s right const", rdat[0], 32'hFFABCDEF);
    popFrame(0, "i2s pop");

    // left-justified 16-bit zero-extended frame
    applyStimulus(1, 32'h8001, 32'h7FFE, 1'b0, 1'b0);
    checkOutput(1, "lj frame");
    checkValue("lj left const", ld[1], 32'h00008001);
    checkValue("lj right const", rdat[1], 32'h00007FFE);
    popFrame(1, "lj pop");

    // short left slot: frame lost, next frame intact
    sendSlot(0, 1'b0, $urandom, 10, 1'b0, 1'b0);
    sendSlot(0, 1'b1, $urandom, 32, 1'b0, 1'b0);
    checkOutput(0, "after short slot");
    applyStimulus(0, $urandom, $urandom, 1'b0, 1'b0);
    checkOutput(0, "recovered frame");
    checkValue("recovered level const", 32'(lvl[0]), 32'd1);
    popFrame(0, "recovered pop");

    // overflow: six frames into a four-deep FIFO
    for (int i = 0; i < 6; i++) applyStimulus(0, $urandom, $urandom, 1'b0, 1'b0);
    checkOutput(0, "overfilled");
    checkValue("overfilled overflow const", 32'(ovf[0]), 32'd1);
    clearOverflow(0);
    checkOutput(0, "overflow cleared");
    for (int i = 0; i < 4; i++) popFrame(0, $sformatf("drain %0d", i));

    // full FIFO with a pop on the push edge
    for (int i = 0; i < 4; i++) applyStimulus(0, $urandom, $urandom, 1'b0, 1'b0);
    applyStimulus(0, $urandom, $urandom, 1'b1, 1'b0);
    checkOutput(0, "full push+pop");
    for (int i = 0; i < 4; i++) popFrame(0, $sformatf("drain2 %0d", i));

    // random left-justified traffic with interleaved pops
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, $urandom, $urandom, 1'b0, 1'b0);
      applyStimulus(1, $urandom, $urandom, 1'b0, 1'b0);
      checkOutput(1, $sformatf("lj rand %0d", i));
      popFrame(1, $sformatf("lj rand pop %0d", i));
    end

    // reset in the middle of a right slot, LRC high at release
    applyStimulus(0, $urandom, $urandom, 1'b0, 1'b0);
    sendSlot(0, 1'b0, $urandom, 32, 1'b0, 1'b0);
    sendSlot(0, 1'b1, $urandom, 12, 1'b0, 1'b0);
    @(negedge aud_bclk);
    rst_n = 1'b0;
    for (int u = 0; u < NU; u++) resetModel(u);
    checkOutput(0, "mid-slot reset u0");
    checkOutput(1, "mid-slot reset u1");
    checkValue("mid-slot reset slot_err", 32'(serr[0]), 32'd0);
    @(negedge aud_bclk);
    rst_n = 1'b1;
    sendSlot(0, 1'b1, $urandom, 20, 1'b0, 1'b0);
    checkOutput(0, "no false slot");
    applyStimulus(0, $urandom, $urandom, 1'b0, 1'b0);
    checkOutput(0, "first frame after reset");
    applyStimulus(1, $urandom, $urandom, 1'b0, 1'b0);
    checkOutput(1, "lj first frame after reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
